// File: rtl/exu_mdu_pkg.sv
// Shared defines for the E-stage multiply/divide unit: RISC-V M opcodes, FSM
// state encoding, iteration constants and operand-signedness helpers.
package exu_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Iteration count for *W ops; full-width ops iterate XLEN times.
    localparam int N_WORD = 32;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input mdu_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic src1_signed(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic src2_signed(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/exu_mdu_div.sv
// Iterative restoring divider datapath on operand magnitudes, one quotient bit
// per step. Only built when YSYX_23060251_MDU_DIV_EN is defined.
`ifdef YSYX_23060251_MDU_DIV_EN
module exu_mdu_div #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            load,
    input  logic            step,
    input  logic            word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            q_neg,
    input  logic            r_neg,
    output logic [XLEN-1:0] quo_fix,
    output logic [XLEN-1:0] rem_fix
);

    // dvd_q shifts dividend bits out of the top while quotient bits fill the bottom.
    logic [XLEN-1:0] dvd_q, dvsr_q, rem_q;
    logic [XLEN-1:0] rem_new, quo_new;
    logic [XLEN:0]   trial;
    logic            fits;

    always_comb begin
        trial   = {rem_q, dvd_q[XLEN-1]};
        fits    = trial >= {1'b0, dvsr_q};
        rem_new = fits ? XLEN'(trial - {1'b0, dvsr_q}) : trial[XLEN-1:0];
        quo_new = {dvd_q[XLEN-2:0], fits};
        quo_fix = q_neg ? -quo_new : quo_new;
        rem_fix = r_neg ? -rem_new : rem_new;
    end

    always_ff @(posedge clock) begin
        if (load) begin
            dvd_q  <= word ? dividend << (XLEN - N_WORD) : dividend;
            dvsr_q <= divisor;
            rem_q  <= '0;
        end else if (step) begin
            dvd_q <= quo_new;
            rem_q <= rem_new;
        end
    end

endmodule
`endif

// File: rtl/exu_mdu.sv
// Iterative multiply/divide unit for the E-pipe (shift-add multiplier + FSM).
// Divider is present only when YSYX_23060251_MDU_DIV_EN is defined.
module exu_mdu
    import exu_mdu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int OP_W = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            E_valid_i,
    output logic            e_ready_o,
    input  logic [OP_W-1:0] op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            e_valid_o,
    input  logic            M_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    mdu_op_e             op, op_q;
    logic                word, word_q, accept, last_step, div_fast;
    logic                neg_a, neg_b, neg_a_q, neg_b_q;
    logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag, mplr_q;
    logic [XLEN-1:0]     mul_half, mul_res, div_res;
    logic [2*XLEN-1:0]   mcand_q, prod_q, prod_sum, prod_fix;

    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic w);
        logic signed [31:0] lo;
        lo = v[31:0];
        return w ? XLEN'(lo) : v;
    endfunction

    assign op        = mdu_op_e'(op_i[2:0]);
    assign word      = (XLEN == 64) && word_i;
    assign accept    = E_valid_i & e_ready_o & ~flush_i;
    assign last_step = cnt_q == CNT_W'(1);

    always_comb begin
        a_ext = word ? (src1_signed(op) ? fmt(src1_i, 1'b1) : XLEN'(src1_i[31:0])) : src1_i;
        b_ext = word ? (src2_signed(op) ? fmt(src2_i, 1'b1) : XLEN'(src2_i[31:0])) : src2_i;
        neg_a = src1_signed(op) & a_ext[XLEN-1];
        neg_b = src2_signed(op) & b_ext[XLEN-1];
        a_mag = neg_a ? -a_ext : a_ext;
        b_mag = neg_b ? -b_ext : b_ext;
    end

`ifdef YSYX_23060251_MDU_DIV_EN
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] min_val, quo_fix, rem_fix, special_res;

    // Divide-by-zero and signed overflow resolve at accept without iterating.
    always_comb begin
        min_val     = word ? fmt(XLEN'(32'h8000_0000), 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero    = b_ext == '0;
        div_ovf     = src1_signed(op) && (a_ext == min_val) && (b_ext == '1);
        div_fast    = div_zero | div_ovf;
        special_res = div_zero ? (op_is_rem(op) ? a_ext : '1)
                               : (op_is_rem(op) ? '0 : a_ext);
        div_res     = fmt(op_is_rem(op_q) ? rem_fix : quo_fix, word_q);
    end

    exu_mdu_div #(.XLEN(XLEN)) u_div (
        .clock    (clock),
        .load     (accept & op_is_div(op)),
        .step     ((state_q == ST_DIV) & ~flush_i),
        .word     (word),
        .dividend (a_mag),
        .divisor  (b_mag),
        .q_neg    (neg_a_q ^ neg_b_q),
        .r_neg    (neg_a_q),
        .quo_fix  (quo_fix),
        .rem_fix  (rem_fix)
    );
`else
    assign div_fast = 1'b1;
    assign div_res  = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = !op_is_div(op) ? ST_MUL : (div_fast ? ST_DONE : ST_DIV);
            ST_MUL:  if (last_step) state_d = ST_DONE;
            ST_DIV:  if (last_step) state_d = ST_DONE;
            ST_DONE: if (M_ready_i) state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_comb begin
        e_ready_o = state_q == ST_IDLE;
        e_valid_o = state_q == ST_DONE;
        busy_o    = state_q != ST_IDLE;
    end

    // Multiply on magnitudes; the sign is applied in the final iteration.
    always_comb begin
        prod_sum = prod_q + (mplr_q[0] ? mcand_q : '0);
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod_sum : prod_sum;
        if (op_q == OP_MUL) mul_half = prod_fix[XLEN-1:0];
        else if (word_q)    mul_half = prod_fix[2*N_WORD-1:N_WORD];
        else                mul_half = prod_fix[2*XLEN-1:XLEN];
        mul_res = fmt(mul_half, word_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            res_o <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= (op_is_div(op) && div_fast) ? '0 : (word ? CNT_W'(N_WORD) : CNT_W'(XLEN));
`ifdef YSYX_23060251_MDU_DIV_EN
            if (op_is_div(op) && div_fast) res_o <= fmt(special_res, word);
`else
            if (op_is_div(op)) res_o <= '0;
`endif
        end else if (state_q == ST_MUL || state_q == ST_DIV) begin
            cnt_q <= cnt_q - 1'b1;
            if (last_step) res_o <= (state_q == ST_MUL) ? mul_res : div_res;
        end
    end

    // NOTE: operand and product registers are fully loaded on accept, so they need no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_q    <= op;
            word_q  <= word;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            mcand_q <= (2*XLEN)'(a_mag);
            mplr_q  <= b_mag;
            prod_q  <= '0;
        end else if (state_q == ST_MUL) begin
            prod_q  <= prod_sum;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
        end
    end

endmodule

// File: tb/tb_exu_mdu.sv
// Self-checking bench for exu_mdu (XLEN=64): directed vector table, randomized
// ops against an arithmetic reference model, and handshake/flush/reset sequences.
module tb_exu_mdu;
    import exu_mdu_pkg::*;

    logic        clock = 1'b0;
    logic        reset, E_valid_i, e_ready_o, word_i, flush_i, e_valid_o, M_ready_i, busy_o;
    logic [2:0]  op_i;
    logic [63:0] src1_i, src2_i, res_o;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    exu_mdu #(.XLEN(64), .OP_W(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .E_valid_i (E_valid_i),
        .e_ready_o (e_ready_o),
        .op_i      (op_i),
        .word_i    (word_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .flush_i   (flush_i),
        .e_valid_o (e_valid_o),
        .M_ready_i (M_ready_i),
        .res_o     (res_o),
        .busy_o    (busy_o)
    );

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: full-precision products and language-level division.
    function automatic void model(input logic [2:0] op, input logic word,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res, output int lat);
        logic signed [129:0] x, y, p;
        logic [31:0] q32, r32;
        logic [63:0] q64, r64;
        logic is_signed, is_rem;
        is_signed = (op == OP_DIV) || (op == OP_REM);
        is_rem    = (op == OP_REM) || (op == OP_REMU);
        q32 = '0; r32 = '0; q64 = '0; r64 = '0;
        if (op < 3'd4) begin
            lat = word ? 33 : 65;
            x = (op == OP_MULHU) ? $signed({66'd0, a}) : $signed({{66{a[63]}}, a});
            y = (op == OP_MULHSU || op == OP_MULHU) ? $signed({66'd0, b}) : $signed({{66{b[63]}}, b});
            p = x * y;
            if (word)               res = sx32(p[31:0]);
            else if (op == OP_MUL)  res = p[63:0];
            else                    res = p[127:64];
        end else begin
`ifdef YSYX_23060251_MDU_DIV_EN
            if (word) begin
                lat = 33;
                if (b[31:0] == 32'd0) begin
                    q32 = '1; r32 = a[31:0]; lat = 1;
                end else if (is_signed && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                    q32 = a[31:0]; r32 = '0; lat = 1;
                end else if (is_signed) begin
                    q32 = $signed(a[31:0]) / $signed(b[31:0]);
                    r32 = $signed(a[31:0]) % $signed(b[31:0]);
                end else begin
                    q32 = a[31:0] / b[31:0];
                    r32 = a[31:0] % b[31:0];
                end
                res = sx32(is_rem ? r32 : q32);
            end else begin
                lat = 65;
                if (b == 64'd0) begin
                    q64 = '1; r64 = a; lat = 1;
                end else if (is_signed && a == 64'h8000_0000_0000_0000 && b == '1) begin
                    q64 = a; r64 = '0; lat = 1;
                end else if (is_signed) begin
                    q64 = $signed(a) / $signed(b);
                    r64 = $signed(a) % $signed(b);
                end else begin
                    q64 = a / b;
                    r64 = a % b;
                end
                res = is_rem ? r64 : q64;
            end
`else
            res = '0;
            lat = 1;
`endif
        end
    endfunction

    task automatic set_vec(input int i, input logic [2:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] r, input int l);
        vecs[i] = '{op: op, word: w, a: a, b: b, res: r, lat: l};
    endtask

    // Offer one op, then count cycles (accept = cycle 0) until e_valid_o.
    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output int lat);
        @(negedge clock);
        op_i = op; word_i = w; src1_i = a; src2_i = b; E_valid_i = 1'b1;
        @(negedge clock);
        E_valid_i = 1'b0;
        lat = 1;
        while (!e_valid_o && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        res = res_o;
    endtask

    task automatic release_result(input string name);
        M_ready_i = 1'b1;
        @(negedge clock);
        M_ready_i = 1'b0;
        check({name, " ready after release"}, 64'(e_ready_o), 64'd1);
        check({name, " valid after release"}, 64'(e_valid_o), 64'd0);
    endtask

    task automatic watch_no_valid(input string name);
        logic seen;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clock);
            if (e_valid_o) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] got, exp_res, held;
        int          lat, exp_lat;
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;

        reset = 1'b1; E_valid_i = 1'b0; flush_i = 1'b0; M_ready_i = 1'b0;
        op_i = '0; word_i = 1'b0; src1_i = '0; src2_i = '0;

        set_vec(0, OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        set_vec(1, OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65);
        set_vec(2, OP_MUL,    1'b1, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
        set_vec(3, OP_MULH,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65);
        set_vec(4, OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        set_vec(5, OP_MUL,    1'b1, 64'h1_0000_0003, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 33);
`ifdef YSYX_23060251_MDU_DIV_EN
        set_vec(6,  OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        set_vec(7,  OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        set_vec(8,  OP_DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        set_vec(9,  OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        set_vec(10, OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        set_vec(11, OP_REM,  1'b0, 64'd9, 64'd4, 64'd1, 65);
`else
        set_vec(6,  OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1);
        set_vec(7,  OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1);
        set_vec(8,  OP_DIVU, 1'b0, 64'd100, 64'd0, 64'd0, 1);
        set_vec(9,  OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        set_vec(10, OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        set_vec(11, OP_REM,  1'b0, 64'd9, 64'd4, 64'd0, 1);
`endif

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset res", res_o, 64'd0);
        check("reset valid", 64'(e_valid_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset ready", 64'(e_ready_o), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, got, lat);
            check($sformatf("vec%0d res", i), got, vecs[i].res);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            release_result($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = (op == OP_MUL || op >= 3'd4) ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            case ($urandom_range(0, 5))
                0: b = 64'($urandom_range(0, 15));
                1: b = '0;
                2: begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
                3: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            model(op, w, a, b, exp_res, exp_lat);
            run_op(op, w, a, b, got, lat);
            check($sformatf("rnd%0d op%0d w%0d res", i, op, w), got, exp_res);
            check($sformatf("rnd%0d latency", i), 64'(lat), 64'(exp_lat));
            release_result($sformatf("rnd%0d", i));
        end

        // Back-pressure: result must hold while M-pipe stalls.
        run_op(OP_MUL, 1'b0, 64'd12345, 64'd678, got, lat);
        check("hold res", got, 64'd8369910);
        held = got;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check($sformatf("hold%0d res", i), res_o, held);
            check($sformatf("hold%0d ready", i), 64'(e_ready_o), 64'd0);
            check($sformatf("hold%0d valid", i), 64'(e_valid_o), 64'd1);
        end
        M_ready_i = 1'b1;
        @(negedge clock);
        M_ready_i = 1'b0;
        check("hold release ready", 64'(e_ready_o), 64'd1);
        check("hold release valid", 64'(e_valid_o), 64'd0);

        // Flush mid-operation at cycle 20.
        @(negedge clock);
`ifdef YSYX_23060251_MDU_DIV_EN
        op_i = OP_DIV;
`else
        op_i = OP_MUL;
`endif
        word_i = 1'b0; src1_i = 64'd1000; src2_i = 64'd7; E_valid_i = 1'b1;
        @(negedge clock);
        E_valid_i = 1'b0;
        repeat (19) @(negedge clock);
        check("flush busy before", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        @(negedge clock);
        flush_i = 1'b0;
        check("flush busy", 64'(busy_o), 64'd0);
        check("flush valid", 64'(e_valid_o), 64'd0);
        check("flush ready", 64'(e_ready_o), 64'd1);
        watch_no_valid("flush no late valid");

        // Offer with flush high: must not be accepted.
        @(negedge clock);
        op_i = OP_MUL; src1_i = 64'd3; src2_i = 64'd5; E_valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clock);
        E_valid_i = 1'b0; flush_i = 1'b0;
        check("flush offer busy", 64'(busy_o), 64'd0);
        check("flush offer ready", 64'(e_ready_o), 64'd1);
        watch_no_valid("flush offer no valid");

        // Reset at cycle 10 of a multiply.
        @(negedge clock);
        op_i = OP_MUL; src1_i = 64'd11; src2_i = 64'd13; E_valid_i = 1'b1;
        @(negedge clock);
        E_valid_i = 1'b0;
        repeat (9) @(negedge clock);
        check("midreset busy before", 64'(busy_o), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset busy", 64'(busy_o), 64'd0);
        check("midreset res", res_o, 64'd0);
        check("midreset valid", 64'(e_valid_o), 64'd0);
        check("midreset ready", 64'(e_ready_o), 64'd1);
        watch_no_valid("midreset no valid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
